// File: rtl/exu_bjp_commit_if.sv
// Commit-side handshake between the BJP ALU and the commit stage, plus the IFU flush channel.
interface exu_bjp_commit_if #(
  parameter int XLEN    = 32,
  parameter int PC_SIZE = 32
);
  logic               cmt_i_valid;
  logic               cmt_i_ready;
  logic [PC_SIZE-1:0] cmt_i_pc;
  logic               cmt_i_bjp;
  logic               cmt_i_br;
  logic               cmt_i_bprdt;
  logic               cmt_i_taken;
  logic [XLEN-1:0]    cmt_i_target;
  logic               flush_o_valid;
  logic               flush_o_ready;
  logic [PC_SIZE-1:0] flush_o_pc;
  logic               cmt_o_kill;

  modport slave (
    input  cmt_i_valid, cmt_i_pc, cmt_i_bjp, cmt_i_br, cmt_i_bprdt, cmt_i_taken, cmt_i_target,
    input  flush_o_ready,
    output cmt_i_ready, flush_o_valid, flush_o_pc, cmt_o_kill
  );

  modport master (
    output cmt_i_valid, cmt_i_pc, cmt_i_bjp, cmt_i_br, cmt_i_bprdt, cmt_i_taken, cmt_i_target,
    output flush_o_ready,
    input  cmt_i_ready, flush_o_valid, flush_o_pc, cmt_o_kill
  );
endinterface

// File: rtl/exu_bjp_commit.sv
// BJP commit: checks resolved outcome against IFU prediction, issues a held flush on mispredict,
// and keeps wrapping commit/mispredict counters.
module exu_bjp_commit #(
  parameter int XLEN    = 32,
  parameter int PC_SIZE = 32,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  exu_bjp_commit_if.slave  cmt,
  output logic [CNT_W-1:0] perf_o_cmt_cnt,
  output logic [CNT_W-1:0] perf_o_mis_cnt
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  logic [0:0]         state, state_nxt;
  logic               accept, is_bjp, actual_taken, mis;
  logic [PC_SIZE-1:0] next_pc, flush_pc;
  logic [XLEN-1:0]    unused_target;

  assign unused_target   = cmt.cmt_i_target;

  assign cmt.cmt_i_ready = (state == IDLE);
  assign accept          = cmt.cmt_i_valid & cmt.cmt_i_ready;
  assign is_bjp          = cmt.cmt_i_bjp | cmt.cmt_i_br;
  assign actual_taken    = cmt.cmt_i_bjp | (cmt.cmt_i_br & cmt.cmt_i_taken);
  assign mis             = accept & is_bjp & (actual_taken != cmt.cmt_i_bprdt);

  // Taken targets are halfword aligned; fall-through wraps naturally at PC_SIZE bits.
  assign next_pc = actual_taken ? {cmt.cmt_i_target[PC_SIZE-1:1], 1'b0}
                                : cmt.cmt_i_pc + PC_SIZE'(4);

  assign cmt.cmt_o_kill    = mis;
  assign cmt.flush_o_valid = (state == FLUSH);
  assign cmt.flush_o_pc    = flush_pc;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mis)               state_nxt = FLUSH;
      FLUSH:   if (cmt.flush_o_ready) state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      flush_pc       <= '0;
      perf_o_cmt_cnt <= '0;
      perf_o_mis_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (mis)             flush_pc       <= next_pc;
      if (accept & is_bjp) perf_o_cmt_cnt <= perf_o_cmt_cnt + CNT_W'(1);
      if (mis)             perf_o_mis_cnt <= perf_o_mis_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_exu_bjp_commit.sv
// Bench for exu_bjp_commit: per-cycle reference model with a flush-PC scoreboard plus directed scenarios.
module tb_exu_bjp_commit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exu_bjp_commit_if #(.XLEN(32), .PC_SIZE(32)) cif ();
  exu_bjp_commit_if #(.XLEN(32), .PC_SIZE(32)) cif2 ();
  logic [31:0] cmt_cnt, mis_cnt;
  logic [1:0]  cmt_cnt2, mis_cnt2;

  exu_bjp_commit #(.XLEN(32), .PC_SIZE(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .cmt(cif.slave),
    .perf_o_cmt_cnt(cmt_cnt), .perf_o_mis_cnt(mis_cnt));

  // Narrow-counter instance exercises counter wrap in a handful of cycles.
  exu_bjp_commit #(.XLEN(32), .PC_SIZE(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cmt(cif2.slave),
    .perf_o_cmt_cnt(cmt_cnt2), .perf_o_mis_cnt(mis_cnt2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference model state, owned by the monitor process only.
  logic [31:0] m_cmt = 0, m_mis = 0, m_fpc = 0;
  logic        m_flush = 1'b0, prev_fv = 1'b0;
  logic [31:0] sb_q[$];

  initial forever begin
    logic acc, at, mis_e;
    logic [31:0] npc;
    @(negedge clk);
    if (!rst_n) begin
      m_cmt = 0; m_mis = 0; m_flush = 1'b0; sb_q.delete();
      chk("rst_cmt_cnt", cmt_cnt, 0);
      chk("rst_mis_cnt", mis_cnt, 0);
      chk("rst_flush_valid", cif.flush_o_valid, 0);
      chk("rst_kill", cif.cmt_o_kill, 0);
    end else begin
      chk("cmt_cnt", cmt_cnt, m_cmt);
      chk("mis_cnt", mis_cnt, m_mis);
      chk("flush_valid", cif.flush_o_valid, m_flush);
      chk("cmt_ready", cif.cmt_i_ready, !m_flush);
      if (cif.flush_o_valid && !prev_fv) begin
        chk("flush_sb_nonempty", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          m_fpc = sb_q.pop_front();
          chk("flush_pc", cif.flush_o_pc, m_fpc);
        end
      end else if (cif.flush_o_valid && prev_fv) begin
        chk("flush_pc_hold", cif.flush_o_pc, m_fpc);
      end
      acc   = cif.cmt_i_valid & !m_flush;
      at    = cif.cmt_i_bjp | (cif.cmt_i_br & cif.cmt_i_taken);
      mis_e = acc & (cif.cmt_i_bjp | cif.cmt_i_br) & (at != cif.cmt_i_bprdt);
      npc   = at ? {cif.cmt_i_target[31:1], 1'b0} : cif.cmt_i_pc + 32'd4;
      chk("kill", cif.cmt_o_kill, mis_e);
      if (acc & (cif.cmt_i_bjp | cif.cmt_i_br)) m_cmt++;
      if (mis_e) begin
        m_mis++;
        sb_q.push_back(npc);
      end
      if (m_flush && cif.flush_o_ready) m_flush = 1'b0;
      else if (mis_e)                   m_flush = 1'b1;
    end
    prev_fv = cif.flush_o_valid;
  end

  task automatic drive(input logic [31:0] pc, input logic bjp, input logic br,
                       input logic prdt, input logic taken, input logic [31:0] tgt);
    cif.cmt_i_valid  = 1'b1;
    cif.cmt_i_pc     = pc;
    cif.cmt_i_bjp    = bjp;
    cif.cmt_i_br     = br;
    cif.cmt_i_bprdt  = prdt;
    cif.cmt_i_taken  = taken;
    cif.cmt_i_target = tgt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ack();
    cif.flush_o_ready = 1'b1;
    step();
    cif.flush_o_ready = 1'b0;
  endtask

  initial begin
    cif.cmt_i_valid = 0; cif.cmt_i_pc = 0; cif.cmt_i_bjp = 0; cif.cmt_i_br = 0;
    cif.cmt_i_bprdt = 0; cif.cmt_i_taken = 0; cif.cmt_i_target = 0; cif.flush_o_ready = 0;
    cif2.cmt_i_valid = 0; cif2.cmt_i_pc = 0; cif2.cmt_i_bjp = 0; cif2.cmt_i_br = 0;
    cif2.cmt_i_bprdt = 0; cif2.cmt_i_taken = 0; cif2.cmt_i_target = 0; cif2.flush_o_ready = 0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("init_ready", cif.cmt_i_ready, 1);
    chk("init_flush_pc", cif.flush_o_pc, 0);

    // correctly predicted JAL
    drive(32'h8000_0000, 1, 0, 1, 0, 32'h8000_0100);
    step();
    cif.cmt_i_valid = 0;
    chk("jal_cmt_cnt", cmt_cnt, 1);
    chk("jal_no_flush", cif.flush_o_valid, 0);
    chk("jal_ready", cif.cmt_i_ready, 1);

    // taken branch predicted not-taken, odd target gets aligned
    drive(32'h8000_0010, 0, 1, 0, 1, 32'h8000_0041);
    #1 chk("br_kill", cif.cmt_o_kill, 1);
    step();
    cif.cmt_i_valid = 0;
    chk("br_flush_valid", cif.flush_o_valid, 1);
    chk("br_flush_pc", cif.flush_o_pc, 32'h8000_0040);
    chk("br_mis_cnt", mis_cnt, 1);
    ack();
    chk("br_ack_valid", cif.flush_o_valid, 0);
    chk("br_ack_ready", cif.cmt_i_ready, 1);

    // not-taken branch predicted taken at top of address space: fall-through wraps
    drive(32'hFFFF_FFFC, 0, 1, 1, 0, 32'h1234_5678);
    step();
    chk("wrap_flush_pc", cif.flush_o_pc, 32'h0);
    drive(32'h0000_0100, 1, 0, 1, 0, 32'h0000_0200);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", cif.flush_o_valid, 1);
      chk("hold_pc", cif.flush_o_pc, 32'h0);
      chk("hold_ready", cif.cmt_i_ready, 0);
      step();
    end
    ack();
    chk("wrap_ack_valid", cif.flush_o_valid, 0);
    chk("wrap_ack_ready", cif.cmt_i_ready, 1);
    chk("wrap_no_reaccept", cmt_cnt, 3);
    step();
    cif.cmt_i_valid = 0;
    chk("wrap_after_accept", cmt_cnt, 4);

    // 10 back-to-back correctly predicted branches
    for (int i = 0; i < 10; i++) begin
      drive(32'h9000_0000 + 32'(i * 4), 0, 1, i[0], i[0], 32'h9000_1000);
      chk("b2b_ready", cif.cmt_i_ready, 1);
      step();
    end
    cif.cmt_i_valid = 0;
    chk("b2b_cmt_cnt", cmt_cnt, 14);
    chk("b2b_mis_cnt", mis_cnt, 2);

    // random mix with random ack delay; scoreboard checks flush PCs
    for (int i = 0; i < 40; i++) begin
      drive($urandom, 1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
            1'($urandom), $urandom);
      if ($urandom_range(0, 4) == 0) cif.cmt_i_valid = 0;
      step();
      cif.cmt_i_valid = 0;
      if (cif.flush_o_valid) begin
        repeat ($urandom_range(0, 3)) step();
        ack();
      end
    end

    // async reset while a flush is pending
    drive(32'h8000_0000, 1, 0, 0, 0, 32'h8000_0800);
    step();
    cif.cmt_i_valid = 0;
    chk("pre_rst_flush_valid", cif.flush_o_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_flush_valid", cif.flush_o_valid, 0);
    chk("arst_cmt_cnt", cmt_cnt, 0);
    chk("arst_mis_cnt", mis_cnt, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("arst_ready", cif.cmt_i_ready, 1);

    // counter wrap on the 2-bit instance: four mispredicting jumps
    for (int i = 0; i < 4; i++) begin
      cif2.cmt_i_valid = 1; cif2.cmt_i_bjp = 1; cif2.cmt_i_bprdt = 0;
      cif2.cmt_i_pc = 32'h100; cif2.cmt_i_target = 32'h0000_0203;
      step();
      cif2.cmt_i_valid = 0;
      chk("c2_flush_pc", cif2.flush_o_pc, 32'h0000_0202);
      if (i == 2) begin
        chk("c2_cmt_pre", cmt_cnt2, 3);
        chk("c2_mis_pre", mis_cnt2, 3);
      end
      cif2.flush_o_ready = 1;
      step();
      cif2.flush_o_ready = 0;
    end
    chk("c2_cmt_wrap", cmt_cnt2, 0);
    chk("c2_mis_wrap", mis_cnt2, 0);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
